// File: rtl/shiftblock_feeder.sv
// shiftblock_feeder: fetches 32-bit words and writes them byte-by-byte into the shift-block coprocessor. Rev 1.0
// Optional irq output and irq_en control bit: define SHIFTFEED_IRQ_EN.
`default_nettype none

module shiftblock_feeder #(
  parameter int         LEN_WIDTH = 16,
  parameter logic [3:0] SINK_ADDR = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] m_rd_address,
  output logic        m_rd_read,
  input  logic [31:0] m_rd_readdata,
  input  logic        m_rd_waitrequest,
  input  logic        m_rd_readdatavalid,
  output logic [3:0]  m_wr_address,
  output logic        m_wr_write,
  output logic [31:0] m_wr_writedata,
  output logic [3:0]  m_wr_byteenable,
  input  logic        m_wr_waitrequest
`ifdef SHIFTFEED_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RDREQ  = 3'd1,
    RDWAIT = 3'd2,
    WRBYTE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  state_t               state, state_nx;
  logic [31:0]          src;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] sent;
  logic [31:0]          addr;
  logic [31:0]          word;
  logic [1:0]           bi;
  logic                 done;
  logic                 busy;
  logic                 ctrl_wr;
  logic                 start;
  logic                 rd_data;
  logic                 wr_accept;
  logic                 last_byte;
  logic [31:0]          status_word;
  logic                 unused_ok;

  assign unused_ok = s_read;
  assign busy      = (state != IDLE);
  assign ctrl_wr   = s_write && (s_address == 2'd2);
  assign start     = ctrl_wr && s_writedata[0] && (state == IDLE);
  assign rd_data   = (state == RDWAIT) && m_rd_readdatavalid;
  assign wr_accept = (state == WRBYTE) && !m_wr_waitrequest;
  assign last_byte = ((sent + LEN_ONE) == len);

`ifdef SHIFTFEED_IRQ_EN
  logic irq_en;
  assign irq = done & irq_en;
`endif

  always_comb begin
    state_nx   = state;
    m_rd_read  = 1'b0;
    m_wr_write = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (len == '0) ? DONE : RDREQ;
      end
      RDREQ: begin
        m_rd_read = 1'b1;
        if (!m_rd_waitrequest) state_nx = RDWAIT;
      end
      RDWAIT: begin
        if (m_rd_readdatavalid) state_nx = WRBYTE;
      end
      WRBYTE: begin
        m_wr_write = 1'b1;
        if (!m_wr_waitrequest) begin
          if (last_byte)       state_nx = DONE;
          else if (bi == 2'd3) state_nx = RDREQ;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      src   <= '0;
      len   <= '0;
      sent  <= '0;
      addr  <= '0;
      word  <= '0;
      bi    <= '0;
      done  <= 1'b0;
`ifdef SHIFTFEED_IRQ_EN
      irq_en <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (s_write && (state == IDLE)) begin
        if (s_address == 2'd0) src <= {s_writedata[31:2], 2'b00};
        if (s_address == 2'd1) len <= s_writedata[LEN_WIDTH-1:0];
      end
`ifdef SHIFTFEED_IRQ_EN
      if (ctrl_wr) irq_en <= s_writedata[1];
      if (s_write && (s_address == 2'd3)) done <= 1'b0;
`endif
      if (start) begin
        done <= 1'b0;
        if (len != '0) begin
          addr <= src;
          sent <= '0;
          bi   <= '0;
        end
      end
      if (rd_data) begin
        word <= m_rd_readdata;
        addr <= addr + 32'd4;
      end
      if (wr_accept) begin
        sent <= sent + LEN_ONE;
        bi   <= bi + 2'd1;
      end
      // Placed last so a same-cycle STATUS write cannot lose a completion.
      if (state == DONE) done <= 1'b1;
    end
  end

  assign m_rd_address    = addr;
  assign m_wr_address    = SINK_ADDR;
  assign m_wr_writedata  = {24'h0, word[{bi, 3'b000} +: 8]};
  assign m_wr_byteenable = m_wr_write ? 4'h1 : 4'h0;

  always_comb begin
    status_word                 = '0;
    status_word[0]              = busy;
    status_word[1]              = done;
    status_word[16+:LEN_WIDTH]  = sent;
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      2'd0: s_readdata = src;
      2'd1: s_readdata = {{(32-LEN_WIDTH){1'b0}}, len};
`ifdef SHIFTFEED_IRQ_EN
      2'd2: s_readdata = {30'b0, irq_en, 1'b0};
`else
      2'd2: s_readdata = '0;
`endif
      default: s_readdata = status_word;
    endcase
  end

endmodule

`default_nettype wire
